// File: rtl/v_tile_pkg.sv
// Shared types and defaults for the v_tile job sequencer.
package v_tile_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CFG  = 3'd1,
    OPND = 3'd2,
    FIRE = 3'd3,
    RSP  = 3'd4
  } seq_state_t;

  localparam int WIDTH_DEF   = 16;
  localparam int LANES_DEF   = 4;
  localparam int NUM_REQ_DEF = 2;
  localparam int TIMEOUT_DEF = 256;

  // Requester-ID width; a single requester still gets a 1-bit ID.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/v_tile_sequencer_arb.sv
// Round-robin arbiter: one-hot grant starting the search at the pointer;
// the pointer moves past the winner when the grant is taken.
module rr_arbiter
  import v_tile_pkg::*;
#(
  parameter int num_req = NUM_REQ_DEF
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [num_req-1:0]              req,
  input  logic                            advance,
  output logic [num_req-1:0]              grant,
  output logic [id_width(num_req)-1:0]    grant_id
);

  localparam int IW = id_width(num_req);

  logic [IW-1:0] ptr;
  int            idx;

  // Scan from the farthest offset down so the nearest requester wins.
  always_comb begin
    grant    = '0;
    grant_id = '0;
    idx      = 0;
    for (int k = num_req - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % num_req;
      if (req[idx]) begin
        grant      = '0;
        grant[idx] = 1'b1;
        grant_id   = IW'(idx);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= (grant_id == IW'(num_req - 1)) ? '0 : grant_id + 1'b1;
    end
  end

endmodule

// File: rtl/v_tile_sequencer.sv
// Shares one v_tile among several requesters: arbitrate, write config
// (skipped on a cache hit), write both operands, fire the adder, respond.
//   state | meaning
//   IDLE  | offer req_ready to the round-robin winner, latch the job
//   CFG   | config write on port 3
//   OPND  | operand writes on ports 1 and 2, independently
//   FIRE  | on_off high until adder_ack, capture result
//   RSP   | rsp_valid held until rsp_ready
module v_tile_sequencer
  import v_tile_pkg::*;
#(
  parameter int width      = WIDTH_DEF,
  parameter int num_inputs = LANES_DEF,
  parameter int num_req    = NUM_REQ_DEF,
  parameter int timeout    = TIMEOUT_DEF
) (
  input  logic                                        clk,
  input  logic                                        reset,
  input  logic [num_req-1:0]                          req_valid,
  output logic [num_req-1:0]                          req_ready,
  input  logic [num_req-1:0][width-1:0]               req_cfg,
  input  logic [num_req-1:0][num_inputs-1:0][width-1:0] req_vec1,
  input  logic [num_req-1:0][num_inputs-1:0][width-1:0] req_vec2,
  output logic                                        rsp_valid,
  input  logic                                        rsp_ready,
  output logic [id_width(num_req)-1:0]                rsp_id,
  output logic [num_inputs-1:0][width-1:0]            rsp_data,
  output logic [3:0]                                  rsp_dest,
  output logic                                        rsp_err,
  output logic                                        write_en1,
  output logic                                        write_en2,
  output logic                                        write_en3,
  input  logic                                        write_rdy1,
  input  logic                                        write_rdy2,
  input  logic                                        write_rdy3,
  input  logic                                        write_ack1,
  input  logic                                        write_ack2,
  input  logic                                        write_ack3,
  output logic [num_inputs-1:0][width-1:0]            w_data_in1,
  output logic [num_inputs-1:0][width-1:0]            w_data_in2,
  output logic [width-1:0]                            w_data_in3,
  output logic                                        on_off,
  input  logic [num_inputs-1:0][width-1:0]            adder_outputs,
  input  logic [3:0]                                  dest_info,
  input  logic                                        adder_ack
);

  localparam int IW = id_width(num_req);
  localparam int TW = $clog2(timeout + 1);

  seq_state_t          state, state_nx;
  logic [num_req-1:0]  grant;
  logic [IW-1:0]       grant_id;
  logic                accept, cfg_hit, wd_hit;
  logic                done1, done2, op1_fin, op2_fin;
  logic [width-1:0]    last_cfg;
  logic                cfg_cached;
  logic [TW-1:0]       wd_cnt;

  rr_arbiter #(.num_req(num_req)) u_arb (
    .clk      (clk),
    .reset    (reset),
    .req      (req_valid),
    .advance  (accept),
    .grant    (grant),
    .grant_id (grant_id)
  );

  assign req_ready = ((state == IDLE) && reset) ? grant : '0;
  assign accept    = |(req_valid & req_ready);
  assign cfg_hit   = cfg_cached && (req_cfg[grant_id] == last_cfg);
  assign wd_hit    = (state inside {CFG, OPND, FIRE}) && (wd_cnt == TW'(timeout - 1));
  assign op1_fin   = done1 || (write_en1 && write_ack1);
  assign op2_fin   = done2 || (write_en2 && write_ack2);
  assign rsp_valid = (state == RSP);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (accept) state_nx = cfg_hit ? OPND : CFG;
      CFG:  if (wd_hit) state_nx = RSP;
            else if (write_en3 && write_ack3) state_nx = OPND;
      OPND: if (wd_hit) state_nx = RSP;
            else if (op1_fin && op2_fin) state_nx = FIRE;
      FIRE: if (wd_hit || (on_off && adder_ack)) state_nx = RSP;
      RSP:  if (rsp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wd_cnt     <= '0;
      write_en1  <= 1'b0;
      write_en2  <= 1'b0;
      write_en3  <= 1'b0;
      on_off     <= 1'b0;
      done1      <= 1'b0;
      done2      <= 1'b0;
      w_data_in1 <= '0;
      w_data_in2 <= '0;
      w_data_in3 <= '0;
      rsp_id     <= '0;
      rsp_data   <= '0;
      rsp_dest   <= '0;
      rsp_err    <= 1'b0;
      last_cfg   <= '0;
      cfg_cached <= 1'b0;
    end else begin
      wd_cnt <= (state_nx != state) ? '0 : wd_cnt + 1'b1;

      if (wd_hit) begin
        // A stalled tile leaves its config state unknown: force a rewrite.
        write_en1  <= 1'b0;
        write_en2  <= 1'b0;
        write_en3  <= 1'b0;
        on_off     <= 1'b0;
        rsp_err    <= 1'b1;
        rsp_data   <= '0;
        rsp_dest   <= '0;
        cfg_cached <= 1'b0;
      end else begin
        case (state)
          IDLE: if (accept) begin
            w_data_in1 <= req_vec1[grant_id];
            w_data_in2 <= req_vec2[grant_id];
            w_data_in3 <= req_cfg[grant_id];
            rsp_id     <= grant_id;
            done1      <= 1'b0;
            done2      <= 1'b0;
          end
          CFG: begin
            if (write_en3 && write_ack3) begin
              write_en3  <= 1'b0;
              last_cfg   <= w_data_in3;
              cfg_cached <= 1'b1;
            end else if (!write_en3 && write_rdy3) begin
              write_en3 <= 1'b1;
            end
          end
          OPND: begin
            if (write_en1 && write_ack1) begin
              write_en1 <= 1'b0;
              done1     <= 1'b1;
            end else if (!write_en1 && !done1 && write_rdy1) begin
              write_en1 <= 1'b1;
            end
            if (write_en2 && write_ack2) begin
              write_en2 <= 1'b0;
              done2     <= 1'b1;
            end else if (!write_en2 && !done2 && write_rdy2) begin
              write_en2 <= 1'b1;
            end
          end
          FIRE: begin
            if (on_off && adder_ack) begin
              on_off   <= 1'b0;
              rsp_data <= adder_outputs;
              rsp_dest <= dest_info;
              rsp_err  <= 1'b0;
            end else if (!on_off) begin
              on_off <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_v_tile_sequencer.sv
// Bench for v_tile_sequencer against a behavioural tile stub whose adder
// returns vec1 + vec2 + cfg per lane and dest = cfg[3:0] ^ 4'hA.
module tb_v_tile_sequencer;
  import v_tile_pkg::*;

  localparam int W = 16, L = 4, N = 2, TO = 16;
  typedef logic [L-1:0][W-1:0] lanes_t;

  logic                     clk = 1'b0, reset = 1'b0;
  logic [N-1:0]             req_valid, req_ready;
  logic [N-1:0][W-1:0]      req_cfg;
  logic [N-1:0][L-1:0][W-1:0] req_vec1, req_vec2;
  logic                     rsp_valid, rsp_ready, rsp_err;
  logic [0:0]               rsp_id;
  lanes_t                   rsp_data, w_data_in1, w_data_in2, adder_outputs;
  logic [3:0]               rsp_dest, dest_info;
  logic                     write_en1, write_en2, write_en3;
  logic                     write_rdy1, write_rdy2, write_rdy3;
  logic                     write_ack1, write_ack2, write_ack3;
  logic [W-1:0]             w_data_in3;
  logic                     on_off, adder_ack;

  always #5 clk = ~clk;

  v_tile_sequencer #(.width(W), .num_inputs(L), .num_req(N), .timeout(TO)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_cfg(req_cfg), .req_vec1(req_vec1), .req_vec2(req_vec2),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_dest(rsp_dest), .rsp_err(rsp_err),
    .write_en1(write_en1), .write_en2(write_en2), .write_en3(write_en3),
    .write_rdy1(write_rdy1), .write_rdy2(write_rdy2), .write_rdy3(write_rdy3),
    .write_ack1(write_ack1), .write_ack2(write_ack2), .write_ack3(write_ack3),
    .w_data_in1(w_data_in1), .w_data_in2(w_data_in2), .w_data_in3(w_data_in3),
    .on_off(on_off), .adder_outputs(adder_outputs), .dest_info(dest_info),
    .adder_ack(adder_ack)
  );

  // Tile stub: each ack rises once its strobe has been high for dly cycles.
  int c1 = 0, c2 = 0, c3 = 0, cf = 0;
  int dly1 = 0, dly2 = 0, dly3 = 0, dlyf = 0;
  bit never_ack = 1'b0;

  always @(posedge clk) begin
    c1 <= write_en1 ? c1 + 1 : 0;
    c2 <= write_en2 ? c2 + 1 : 0;
    c3 <= write_en3 ? c3 + 1 : 0;
    cf <= on_off ? cf + 1 : 0;
  end

  assign write_ack1 = write_en1 && (c1 >= dly1);
  assign write_ack2 = write_en2 && (c2 >= dly2);
  assign write_ack3 = write_en3 && (c3 >= dly3);
  assign adder_ack  = on_off && !never_ack && (cf >= dlyf);
  assign dest_info  = w_data_in3[3:0] ^ 4'hA;

  always_comb begin
    adder_outputs = '0;
    for (int i = 0; i < L; i++) adder_outputs[i] = w_data_in1[i] + w_data_in2[i] + w_data_in3;
  end

  int   cyc = 0, en3_rises = 0, en1_fall_cyc = -1, ack2_cyc = -1, on_rise_cyc = -1;
  logic en3_p = 1'b0, en1_p = 1'b0, on_p = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (write_en3 && !en3_p) en3_rises++;
    if (!write_en1 && en1_p) en1_fall_cyc = cyc;
    if (write_ack2) ack2_cyc = cyc;
    if (on_off && !on_p) on_rise_cyc = cyc;
    en3_p = write_en3;
    en1_p = write_en1;
    on_p  = on_off;
  end

  int n_pass = 0, n_total = 0;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic lanes_t mk(input int a, input int b, input int c, input int d);
    lanes_t t;
    t[0] = W'(a); t[1] = W'(b); t[2] = W'(c); t[3] = W'(d);
    return t;
  endfunction

  // Offer a job, wait for the grant, then count cycles from the accept
  // cycle up to the first rsp_valid cycle.
  task automatic submit(input int r, input logic [W-1:0] cfg, input lanes_t v1, input lanes_t v2,
                        output logic [N-1:0] rdy_seen, output int lat, output int waited, output bit ok);
    ok = 1'b1;
    req_cfg[r] = cfg; req_vec1[r] = v1; req_vec2[r] = v2; req_valid[r] = 1'b1;
    #1;
    waited = 0;
    while (!req_ready[r] && waited < 100) begin @(negedge clk); #1; waited++; end
    rdy_seen = req_ready;
    if (!req_ready[r]) ok = 1'b0;
    lat = 1;
    @(negedge clk);
    req_valid[r] = 1'b0;
    #1;
    while (!rsp_valid && lat < 200) begin lat++; @(negedge clk); #1; end
    if (!rsp_valid) ok = 1'b0;
  endtask

  task automatic release_rsp();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  typedef struct {
    int         r;
    logic [W-1:0] cfg;
    lanes_t     v1, v2, exp_d;
    logic [3:0] exp_dest;
    int         exp_lat, exp_rises;
  } job_t;

  job_t jobs[6];

  initial begin
    logic [N-1:0] rdy_seen, exp_rdy;
    int lat, waited, r0, g;
    bit ok;
    lanes_t exp_d;

    jobs[0] = '{0, 16'h0000, mk(1,3,5,7), mk(2,4,6,8), mk(3,7,11,15), 4'hA, 7, 1};
    jobs[1] = '{0, 16'h0000, mk(1,3,5,7), mk(2,4,6,8), mk(3,7,11,15), 4'hA, 5, 0};
    jobs[2] = '{1, 16'h0005, mk(10,20,30,40), mk(1,1,1,1), mk(16,26,36,46), 4'hF, 7, 1};
    jobs[3] = '{1, 16'h0005, mk(100,200,300,400), mk(1,2,3,4), mk(106,207,308,409), 4'hF, 5, 0};
    jobs[4] = '{0, 16'h0005, mk(0,0,0,0), mk(0,0,0,0), mk(5,5,5,5), 4'hF, 5, 0};
    jobs[5] = '{0, 16'h00FF, mk(16'hFF00,1,2,3), mk(1,0,0,0), mk(0,256,257,258), 4'h5, 7, 1};

    req_valid = 2'b01; rsp_ready = 1'b0; req_cfg = '0; req_vec1 = '0; req_vec2 = '0;
    write_rdy1 = 1'b1; write_rdy2 = 1'b1; write_rdy3 = 1'b1;
    #1;
    chk("reset ctrl", {req_ready, rsp_valid, rsp_err, write_en1, write_en2, write_en3, on_off}, '0);
    chk("reset rsp", {rsp_data, rsp_dest, rsp_id, w_data_in3}, '0);
    chk("reset wdata", {w_data_in1, w_data_in2}, '0);
    req_valid = '0;
    @(negedge clk); reset = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      r0 = en3_rises;
      submit(jobs[i].r, jobs[i].cfg, jobs[i].v1, jobs[i].v2, rdy_seen, lat, waited, ok);
      exp_rdy = '0; exp_rdy[jobs[i].r] = 1'b1;
      chk($sformatf("job%0d handshake", i), ok, 1);
      chk($sformatf("job%0d req_ready", i), rdy_seen, exp_rdy);
      chk($sformatf("job%0d accept wait", i), waited, 0);
      chk($sformatf("job%0d rsp_data", i), rsp_data, jobs[i].exp_d);
      chk($sformatf("job%0d rsp_dest", i), rsp_dest, jobs[i].exp_dest);
      chk($sformatf("job%0d rsp_id", i), rsp_id, jobs[i].r);
      chk($sformatf("job%0d rsp_err", i), rsp_err, 0);
      chk($sformatf("job%0d latency", i), lat, jobs[i].exp_lat);
      release_rsp();
      chk($sformatf("job%0d cfg writes", i), en3_rises - r0, jobs[i].exp_rises);
    end

    // Round robin from a fresh pointer with both requesters held valid.
    reset = 1'b0; #2; reset = 1'b1;
    @(negedge clk);
    req_cfg[0] = 16'd3; req_vec1[0] = mk(1,2,3,4); req_vec2[0] = mk(0,0,0,0);
    req_cfg[1] = 16'd3; req_vec1[1] = mk(9,9,9,9); req_vec2[1] = mk(1,1,1,1);
    req_valid = 2'b11;
    for (int j = 0; j < 4; j++) begin
      #1; g = 0;
      while (req_ready == '0 && g < 100) begin @(negedge clk); #1; g++; end
      chk($sformatf("rr%0d grant", j), req_ready, (j % 2 == 0) ? 2'b01 : 2'b10);
      @(negedge clk); #1; lat = 0;
      while (!rsp_valid && lat < 200) begin @(negedge clk); #1; lat++; end
      chk($sformatf("rr%0d rsp_valid", j), rsp_valid, 1);
      chk($sformatf("rr%0d rsp_id", j), rsp_id, j % 2);
      exp_d = (j % 2 == 0) ? mk(4,5,6,7) : mk(13,13,13,13);
      chk($sformatf("rr%0d rsp_data", j), rsp_data, exp_d);
      release_rsp();
    end
    req_valid = '0;

    // Adder never acks: watchdog abort in FIRE on its 16th cycle.
    never_ack = 1'b1;
    r0 = en3_rises;
    submit(0, 16'd7, mk(1,1,1,1), mk(2,2,2,2), rdy_seen, lat, waited, ok);
    chk("abort handshake", ok, 1);
    chk("abort latency", lat, 21);
    chk("abort rsp_err", rsp_err, 1);
    chk("abort rsp_data", {rsp_data, rsp_dest}, '0);
    chk("abort strobes", {on_off, write_en1, write_en2, write_en3}, '0);
    release_rsp();
    never_ack = 1'b0;
    chk("abort cfg writes", en3_rises - r0, 1);

    r0 = en3_rises;
    submit(0, 16'd7, mk(1,2,3,4), mk(0,0,0,0), rdy_seen, lat, waited, ok);
    chk("recover latency", lat, 7);
    chk("recover rsp_err", rsp_err, 0);
    chk("recover rsp_data", rsp_data, mk(8,9,10,11));
    release_rsp();
    chk("recover cfg rewrite", en3_rises - r0, 1);

    // Port 2 acks five cycles after port 1; then a slow consumer.
    dly2 = 5;
    submit(1, 16'd7, mk(5,5,5,5), mk(5,5,5,5), rdy_seen, lat, waited, ok);
    chk("stagger latency", lat, 10);
    chk("stagger en1 fall before ack2", ack2_cyc - en1_fall_cyc, 4);
    chk("stagger on_off after ack2", on_rise_cyc - ack2_cyc, 2);
    exp_d = mk(17,17,17,17);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk); #1;
      chk($sformatf("hold%0d", k), {rsp_valid, rsp_id, rsp_data}, {1'b1, 1'b1, exp_d});
    end
    release_rsp();
    dly2 = 0;

    // Reset while the adder is being fired.
    req_cfg[0] = 16'd9; req_vec1[0] = mk(1,1,1,1); req_vec2[0] = mk(1,1,1,1); req_valid[0] = 1'b1;
    #1; g = 0;
    while (!req_ready[0] && g < 100) begin @(negedge clk); #1; g++; end
    @(negedge clk); req_valid[0] = 1'b0; #1; g = 0;
    while (!on_off && g < 100) begin @(negedge clk); #1; g++; end
    chk("fire reached", on_off, 1);
    #2; reset = 1'b0; #1;
    chk("reset in fire", {write_en1, write_en2, write_en3, on_off, rsp_valid, req_ready}, '0);
    @(negedge clk); reset = 1'b1;
    r0 = en3_rises;
    submit(0, 16'd9, mk(1,1,1,1), mk(1,1,1,1), rdy_seen, lat, waited, ok);
    chk("post-reset latency", lat, 7);
    chk("post-reset rsp_data", rsp_data, mk(11,11,11,11));
    release_rsp();
    chk("post-reset cfg rewrite", en3_rises - r0, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global time limit: got running expected finished");
    $fatal(1);
  end

endmodule
